aes_core_scheduler: RTL and testbench

Shares one iterative AES engine (forward cipher / inverse cipher with a common key schedule) between two requesters. Each requester offers a 128-bit block plus a mode bit. The scheduler grants round-robin, issues a one-cycle start to the engine, and waits for its done pulse, guarded by a watchdog. It then returns the result, tagged with requester id and error flag, over a valid/ready response port. It sits between the crypto engine and the bus-facing request queues.

---
 rtl/aes_core_scheduler_pkg.sv | 20 ++
 rtl/aes_core_scheduler_if.sv | 31 +++
 rtl/aes_core_scheduler_rr_grant2.sv | 11 +
 rtl/aes_core_scheduler.sv | 99 +++++++++
 tb/tb_aes_core_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_core_scheduler_pkg.sv
// Shared types and constants for the AES engine scheduler.
package aes_pkg;
   localparam int   BLOCK_W  = 128;
   localparam logic MODE_ENC = 1'b0;
   localparam logic MODE_DEC = 1'b1;

   typedef logic [0:BLOCK_W-1] block_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} sched_state_e;

   // A requester's offer as captured on grant.
   typedef struct packed {
      logic   mode;
      block_t data;
   } blk_req_t;

   function automatic int nr_of(input int nk);
      return nk + 6;
   endfunction
endpackage

// File: rtl/aes_core_scheduler_if.sv
// Requester, response and engine-side signals of the scheduler.
interface aes_core_scheduler_if;
   import aes_pkg::*;

   logic   req0_valid, req0_ready, req0_mode;
   block_t req0_data;
   logic   req1_valid, req1_ready, req1_mode;
   block_t req1_data;
   logic   rsp_valid, rsp_ready, rsp_id, rsp_err;
   block_t rsp_data;
   logic   core_start, core_mode, core_done;
   block_t core_data, core_result;

   modport slave (
      input  req0_valid, req0_mode, req0_data,
      input  req1_valid, req1_mode, req1_data,
      input  rsp_ready, core_done, core_result,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_err, rsp_data,
      output core_start, core_mode, core_data
   );

   modport master (
      output req0_valid, req0_mode, req0_data,
      output req1_valid, req1_mode, req1_data,
      output rsp_ready, core_done, core_result,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_err, rsp_data,
      input  core_start, core_mode, core_data
   );
endinterface

// File: rtl/aes_core_scheduler_rr_grant2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last time wins.
module aes_rr_grant2 (
   input  logic valid0,
   input  logic valid1,
   input  logic last_grant,
   output logic grant_id,
   output logic grant_any
);
   assign grant_any = valid0 | valid1;
   assign grant_id  = (valid0 && valid1) ? ~last_grant : valid1;
endmodule

// File: rtl/aes_core_scheduler.sv
// Time-shares one iterative AES engine between two requesters, one transaction
// in flight, with a watchdog that forces an error response if the engine hangs.
import aes_pkg::*;

module aes_core_scheduler #(
   parameter int Nk      = 4,
   parameter int TIMEOUT = nr_of(Nk) + 21
) (
   input  logic                 clks,
   input  logic                 reset,
   aes_core_scheduler_if.slave  bus
);
   localparam int             WD_W   = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

   sched_state_e    state;
   logic            last_grant;
   logic            cur_id;
   logic [WD_W-1:0] wd;

   logic     grant_id, grant_any, accept;
   blk_req_t sel_req;

   aes_rr_grant2 u_grant (
      .valid0     (bus.req0_valid),
      .valid1     (bus.req1_valid),
      .last_grant (last_grant),
      .grant_id   (grant_id),
      .grant_any  (grant_any)
   );

   // Gated by reset so no ready leaks out while the block is held in reset.
   assign accept         = reset && (state == IDLE) && grant_any;
   assign bus.req0_ready = accept && !grant_id;
   assign bus.req1_ready = accept &&  grant_id;

   always_comb begin
      sel_req = grant_id ? {bus.req1_mode, bus.req1_data}
                         : {bus.req0_mode, bus.req0_data};
   end

   always_ff @(posedge clks or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         last_grant     <= 1'b1;
         cur_id         <= 1'b0;
         wd             <= '0;
         bus.core_start <= 1'b0;
         bus.core_mode  <= MODE_ENC;
         bus.core_data  <= '0;
         bus.rsp_valid  <= 1'b0;
         bus.rsp_id     <= 1'b0;
         bus.rsp_err    <= 1'b0;
         bus.rsp_data   <= '0;
      end else begin
         bus.core_start <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_any) begin
                  cur_id         <= grant_id;
                  bus.core_mode  <= sel_req.mode;
                  bus.core_data  <= sel_req.data;
                  bus.core_start <= 1'b1;
                  state          <= ISSUE;
               end
            end
            ISSUE: begin
               wd    <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (wd != WD_MAX) wd <= wd + 1'b1;
               // A done landing on the timeout cycle still delivers the result.
               if (bus.core_done) begin
                  bus.rsp_data  <= bus.core_result;
                  bus.rsp_err   <= 1'b0;
                  bus.rsp_id    <= cur_id;
                  bus.rsp_valid <= 1'b1;
                  state         <= RESP;
               end else if (wd == WD_MAX) begin
                  bus.rsp_data  <= '0;
                  bus.rsp_err   <= 1'b1;
                  bus.rsp_id    <= cur_id;
                  bus.rsp_valid <= 1'b1;
                  state         <= RESP;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  last_grant    <= bus.rsp_id;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_aes_core_scheduler.sv
// Directed + randomized bench; AES-128 engine model and arbitration model live here.
module tb_aes_core_scheduler;
   import aes_pkg::*;

   localparam int TO = 31;

   logic clks  = 1'b0;
   logic reset = 1'b0;
   always #5 clks = ~clks;

   aes_core_scheduler_if bus();

   aes_core_scheduler #(.Nk(4)) dut (
      .clks  (clks),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- AES-128 reference ----------------
   logic [7:0] sbox[256];
   logic [7:0] isbox[256];
   logic [7:0] rk[11][16];

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rl(input logic [7:0] b, input int n);
      logic [15:0] w;
      w = {b, b} << n;
      return w[15:8];
   endfunction

   task automatic aes_init(input logic [0:127] key);
      logic [7:0] inv, b, rc, s;
      logic [7:0] w[44][4];
      logic [7:0] t[4];
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         b = inv;
         s = b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
         sbox[x]  = s;
         isbox[s] = 8'(x);
      end
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 4; k++) w[i][k] = key[8*(4*i+k) +: 8];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         for (int k = 0; k < 4; k++) t[k] = w[i-1][k];
         if (i % 4 == 0) begin
            b    = t[0];
            t[0] = sbox[t[1]] ^ rc;
            t[1] = sbox[t[2]];
            t[2] = sbox[t[3]];
            t[3] = sbox[b];
            rc   = xt(rc);
         end
         for (int k = 0; k < 4; k++) w[i][k] = w[i-4][k] ^ t[k];
      end
      for (int r = 0; r < 11; r++)
         for (int c = 0; c < 4; c++)
            for (int k = 0; k < 4; k++) rk[r][4*c+k] = w[4*r+c][k];
   endtask

   function automatic logic [0:127] aes(input logic dec, input logic [0:127] blk);
      logic [7:0] s[16];
      logic [7:0] t[16];
      logic [7:0] a0, a1, a2, a3;
      logic [0:127] o;
      for (int i = 0; i < 16; i++) s[i] = blk[8*i +: 8];
      if (!dec) begin
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[0][i];
         for (int rd = 1; rd <= 10; rd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
            for (int r = 0; r < 4; r++)
               for (int c = 0; c < 4; c++) t[r+4*c] = s[r+4*((c+r)%4)];
            for (int i = 0; i < 16; i++) s[i] = t[i];
            if (rd < 10)
               for (int c = 0; c < 4; c++) begin
                  a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                  s[4*c]   = gm(a0, 2) ^ gm(a1, 3) ^ a2 ^ a3;
                  s[4*c+1] = a0 ^ gm(a1, 2) ^ gm(a2, 3) ^ a3;
                  s[4*c+2] = a0 ^ a1 ^ gm(a2, 2) ^ gm(a3, 3);
                  s[4*c+3] = gm(a0, 3) ^ a1 ^ a2 ^ gm(a3, 2);
               end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[rd][i];
         end
      end else begin
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[10][i];
         for (int rd = 9; rd >= 0; rd--) begin
            for (int r = 0; r < 4; r++)
               for (int c = 0; c < 4; c++) t[r+4*((c+r)%4)] = s[r+4*c];
            for (int i = 0; i < 16; i++) s[i] = isbox[t[i]];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[rd][i];
            if (rd > 0)
               for (int c = 0; c < 4; c++) begin
                  a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                  s[4*c]   = gm(a0, 14) ^ gm(a1, 11) ^ gm(a2, 13) ^ gm(a3, 9);
                  s[4*c+1] = gm(a0, 9) ^ gm(a1, 14) ^ gm(a2, 11) ^ gm(a3, 13);
                  s[4*c+2] = gm(a0, 13) ^ gm(a1, 9) ^ gm(a2, 14) ^ gm(a3, 11);
                  s[4*c+3] = gm(a0, 11) ^ gm(a1, 13) ^ gm(a2, 9) ^ gm(a3, 14);
               end
         end
      end
      for (int i = 0; i < 16; i++) o[8*i +: 8] = s[i];
      return o;
   endfunction

   function automatic logic [0:127] rnd_blk();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- engine model ----------------
   int eng_lat = 10;
   int spur_req = 0;
   int spur_ack = 0;
   int eng_cnt = 0;
   bit eng_busy = 1'b0;
   logic [0:127] eng_res;

   initial begin
      bus.core_done   = 1'b0;
      bus.core_result = '0;
      forever begin
         @(posedge clks);
         #1;
         bus.core_done   = 1'b0;
         bus.core_result = rnd_blk();
         if (!reset) begin
            eng_busy = 1'b0;
         end else if (spur_req != spur_ack) begin
            spur_ack      = spur_req;
            bus.core_done = 1'b1;
         end else if (eng_busy) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
               bus.core_done   = 1'b1;
               bus.core_result = eng_res;
               eng_busy        = 1'b0;
            end
         end
         if (reset && bus.core_start && eng_lat > 0) begin
            eng_busy = 1'b1;
            eng_cnt  = eng_lat;
            eng_res  = aes(bus.core_mode, bus.core_data);
         end
      end
   end

   // ---------------- stimulus and arbitration model ----------------
   bit           v[2];
   logic         m[2];
   logic [0:127] d[2];
   bit           mlast;
   logic [0:127] got;

   task automatic tick;
      @(posedge clks);
      #2;
   endtask

   task automatic chk(input string tag, input logic [271:0] obs, input logic [271:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic apply;
      bus.req0_valid = v[0]; bus.req0_mode = m[0]; bus.req0_data = d[0];
      bus.req1_valid = v[1]; bus.req1_mode = m[1]; bus.req1_data = d[1];
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk(tag, {bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_err,
                bus.rsp_data, bus.core_start, bus.core_mode, bus.core_data}, '0);
   endtask

   task automatic do_reset;
      reset = 1'b0;
      mlast = 1'b1;
      v[0] = 1'b0; v[1] = 1'b0;
      apply();
      bus.rsp_ready = 1'b0;
      tick();
      tick();
      chk_outputs_zero("reset_state");
      reset = 1'b1;
      tick();
   endtask

   // One transaction starting in the cycle the request should be accepted.
   task automatic txn(input string tag, input int lat, input bit keep, input int hold,
                      output logic [0:127] rdat);
      int           id, n;
      logic         ee, om;
      logic [0:127] ed, od;
      id = (v[0] && v[1]) ? int'(!mlast) : (v[1] ? 1 : 0);
      ee = (lat == 0) || (lat > TO + 1);
      od = d[id];
      om = m[id];
      ed = ee ? '0 : aes(om, od);
      eng_lat = lat;
      #1;
      chk({tag, "_ready"}, {bus.req0_ready, bus.req1_ready}, (id == 1) ? 2'b01 : 2'b10);
      tick();
      if (keep) begin
         d[id] = rnd_blk();
         m[id] = 1'($urandom);
      end else begin
         v[id] = 1'b0;
      end
      if (hold > 0 && !v[1-id]) begin
         v[1-id] = 1'b1;
         d[1-id] = rnd_blk();
         m[1-id] = 1'($urandom);
      end
      apply();
      chk({tag, "_start"}, {bus.core_start, bus.core_mode, bus.core_data}, {1'b1, om, od});
      n = 0;
      while (!bus.rsp_valid && n < 200) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, 272'(n), 272'(ee ? TO + 2 : lat + 1));
      chk({tag, "_rsp"}, {bus.rsp_id, bus.rsp_err, bus.rsp_data}, {1'(id), ee, ed});
      rdat = bus.rsp_data;
      for (int i = 0; i < hold; i++) begin
         if (i == hold / 2) spur_req++;
         tick();
         chk({tag, "_hold"}, {bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data,
                              bus.req0_ready, bus.req1_ready},
                             {1'b1, 1'(id), ee, ed, 2'b00});
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      mlast = 1'(id);
      chk({tag, "_drop"}, 272'(bus.rsp_valid), 272'(0));
   endtask

   initial begin
      v[0] = 1'b0; v[1] = 1'b0;
      m[0] = MODE_ENC; m[1] = MODE_ENC;
      d[0] = '0; d[1] = '0;
      mlast = 1'b1;
      apply();
      bus.rsp_ready = 1'b0;
      aes_init(128'h000102030405060708090a0b0c0d0e0f);

      do_reset();

      // single decrypt, L = 10
      v[0] = 1'b1; m[0] = MODE_DEC; d[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      apply();
      txn("dec0", 10, 1'b0, 0, got);
      chk("dec0_vector", 272'(got), 272'(128'h00112233445566778899aabbccddeeff));

      // tie straight after reset: requester 0 first
      do_reset();
      v[0] = 1'b1; m[0] = MODE_DEC; d[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      v[1] = 1'b1; m[1] = MODE_ENC; d[1] = 128'h00112233445566778899aabbccddeeff;
      apply();
      txn("tie_r0", 7, 1'b0, 0, got);
      txn("tie_r1", 4, 1'b0, 0, got);
      chk("tie_r1_vector", 272'(got), 272'(128'h69c4e0d86a7b0430d8cdb78070b4c55a));

      // fairness: both held valid
      for (int i = 0; i < 2; i++) begin
         v[i] = 1'b1; d[i] = rnd_blk(); m[i] = 1'($urandom);
      end
      apply();
      for (int k = 0; k < 6; k++) txn("rr", 1 + int'($urandom_range(7)), 1'b1, 0, got);
      v[0] = 1'b0; v[1] = 1'b0;

      // watchdog expiry, recovery, then done exactly on the timeout cycle
      v[0] = 1'b1; d[0] = rnd_blk(); m[0] = MODE_ENC;
      apply();
      txn("wdog", 0, 1'b0, 0, got);
      v[1] = 1'b1; d[1] = rnd_blk(); m[1] = MODE_DEC;
      apply();
      txn("wdog_next", 5, 1'b0, 0, got);
      v[0] = 1'b1; d[0] = rnd_blk();
      apply();
      txn("wdog_edge", TO + 1, 1'b0, 0, got);

      // backpressure with a spurious done during RESP
      v[0] = 1'b1; d[0] = rnd_blk(); m[0] = MODE_DEC;
      apply();
      txn("bp", 4, 1'b0, 20, got);
      txn("bp_next", 3, 1'b0, 0, got);

      // reset three cycles into the engine run
      v[0] = 1'b1; d[0] = rnd_blk(); m[0] = MODE_ENC;
      apply();
      eng_lat = 20;
      #1;
      chk("rst_ready", {bus.req0_ready, bus.req1_ready}, 2'b10);
      tick();
      v[0] = 1'b0;
      apply();
      tick(); tick(); tick();
      reset = 1'b0;
      mlast = 1'b1;
      #1;
      chk_outputs_zero("rst_async");
      tick(); tick();
      reset = 1'b1;
      chk_outputs_zero("rst_quiet");
      v[1] = 1'b1; d[1] = rnd_blk(); m[1] = MODE_DEC;
      apply();
      txn("rst_req1", 6, 1'b0, 0, got);

      // randomized traffic
      for (int k = 0; k < 12; k++) begin
         if (!v[0] && !v[1]) begin
            for (int i = 0; i < 2; i++) begin
               v[i] = 1'($urandom);
               d[i] = rnd_blk();
               m[i] = 1'($urandom);
            end
            if (!v[0] && !v[1]) v[$urandom_range(1)] = 1'b1;
            apply();
         end
         txn("rand", 1 + int'($urandom_range(11)), 1'($urandom),
             int'($urandom_range(3)), got);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
